// File: rtl/lcd_if_host_if.sv
// lcd_if_host_if: display scan, frame-buffer read and keypad signals between lcd_if_host (master) and user logic (slave)
interface lcd_if_host_if;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic [5:0]  rd_addr;
    logic        rd_valid;
    logic [39:0] rd_name;
    logic [31:0] rd_value;
    logic        frame_done;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [31:0] entry_value;
    logic [3:0]  entry_digits;
    logic        input_valid;
    logic [31:0] input_value;
    modport master (
        output display_number, rd_valid, rd_name, rd_value, frame_done,
               entry_value, entry_digits, input_valid, input_value,
        input  display_valid, display_name, display_value, rd_addr, key_valid, key_code
    );
    modport slave (
        input  display_number, rd_valid, rd_name, rd_value, frame_done,
               entry_value, entry_digits, input_valid, input_value,
        output display_valid, display_name, display_value, rd_addr, key_valid, key_code
    );
endinterface

// File: rtl/lcd_if_host.sv
// lcd_if_host: scans 44 display areas into a frame buffer and assembles hex keypad entries; LCD_SCAN_HOLD_EN adds a scan_hold input
module lcd_if_host #(
    parameter int DWELL = 2
) (
    input logic clk,
    input logic reset,
`ifdef LCD_SCAN_HOLD_EN
    input logic scan_hold,
`endif
    lcd_if_host_if.master bus
);
    localparam logic [3:0] LAST = 4'(DWELL - 1);

    logic        hold;
    logic [3:0]  cnt;
    logic        wr;
    logic        in_range;
    logic [63:0] valid_mem;
    logic [39:0] name_mem [64];
    logic [31:0] value_mem [64];

`ifdef LCD_SCAN_HOLD_EN
    assign hold = scan_hold;
`else
    assign hold = 1'b0;
`endif

    assign wr       = !hold && cnt == LAST;
    assign in_range = bus.rd_addr >= 6'd1 && bus.rd_addr <= 6'd44;

    // scan counter: dwell count and area number, frame_done one cycle after the area-44 capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                <= '0;
            bus.display_number <= 6'd1;
            bus.frame_done     <= 1'b0;
        end else begin
            bus.frame_done <= wr && bus.display_number == 6'd44;
            if (!hold) begin
                cnt <= wr ? 4'd0 : cnt + 4'd1;
                if (wr)
                    bus.display_number <= bus.display_number == 6'd44 ? 6'd1 : bus.display_number + 6'd1;
            end
        end
    end

    // valid bits are the only buffer state that must clear on reset
    always_ff @(posedge clk) begin
        if (reset)
            valid_mem <= '0;
        else if (wr)
            valid_mem[bus.display_number] <= bus.display_valid;
    end

    // label and value storage, meaningful only where the valid bit is set
    always_ff @(posedge clk) begin
        if (wr) begin
            name_mem[bus.display_number]  <= bus.display_name;
            value_mem[bus.display_number] <= bus.display_value;
        end
    end

    // registered read port; a same-cycle write is seen on the following read
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_name  <= '0;
            bus.rd_value <= '0;
        end else begin
            bus.rd_valid <= in_range && valid_mem[bus.rd_addr];
            bus.rd_name  <= in_range ? name_mem[bus.rd_addr] : 40'd0;
            bus.rd_value <= in_range ? value_mem[bus.rd_addr] : 32'd0;
        end
    end

    // keypad entry: shift in digits, backspace, clear, commit on enter
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.entry_value  <= '0;
            bus.entry_digits <= '0;
            bus.input_valid  <= 1'b0;
            bus.input_value  <= '0;
        end else begin
            bus.input_valid <= bus.key_valid && bus.key_code == 5'd18 && bus.entry_digits != 4'd0;
            if (bus.key_valid) begin
                if (!bus.key_code[4] && bus.entry_digits != 4'd8) begin
                    bus.entry_value  <= {bus.entry_value[27:0], bus.key_code[3:0]};
                    bus.entry_digits <= bus.entry_digits + 4'd1;
                end else if (bus.key_code == 5'd16 && bus.entry_digits != 4'd0) begin
                    bus.entry_value  <= bus.entry_value >> 4;
                    bus.entry_digits <= bus.entry_digits - 4'd1;
                end else if (bus.key_code == 5'd17 || (bus.key_code == 5'd18 && bus.entry_digits != 4'd0)) begin
                    bus.entry_value  <= '0;
                    bus.entry_digits <= '0;
                end
                if (bus.key_code == 5'd18 && bus.entry_digits != 4'd0)
                    bus.input_value <= bus.entry_value;
            end
        end
    end
endmodule
